// File: rtl/id_stage.sv
// Decode stage: register file, MIPS-subset decode, ID/EX register, load-use stall (optional RF_WRITE_BYPASS_EN).
// Latency: one cycle from Ins/nextPC to the out_* fields; register-file write lands on the same edge.
// Backpressure: stall is combinational and holds fetch for one cycle on a load-use hazard; a bubble fills ID/EX.
module id_stage #(
   parameter int REG_NUM = 32,
   parameter int DATA_W  = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [31:0]       Ins,
   input  logic [DATA_W-1:0] nextPC,
   input  logic              in_valid,
   input  logic              flush,
   input  logic              wb_we,
   input  logic [4:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              stall,
   output logic              illegal,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_pc4,
   output logic [DATA_W-1:0] out_rs_data,
   output logic [DATA_W-1:0] out_rt_data,
   output logic [DATA_W-1:0] out_imm,
   output logic [4:0]        out_rs,
   output logic [4:0]        out_rt,
   output logic [4:0]        out_rd,
   output logic [5:0]        out_funct,
   output logic              out_regwrite,
   output logic              out_memread,
   output logic              out_memwrite,
   output logic              out_branch,
   output logic              out_alusrc,
   output logic              out_regdst,
   output logic              out_memtoreg
);

   typedef struct packed {
      logic regwrite;
      logic memread;
      logic memwrite;
      logic branch;
      logic alusrc;
      logic regdst;
      logic memtoreg;
   } ctl_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   logic [DATA_W-1:0] regs [REG_NUM];

   logic [5:0]        op;
   logic [4:0]        rs_idx;
   logic [4:0]        rt_idx;
   logic [4:0]        rd_idx;
   logic [DATA_W-1:0] imm_ext;
   logic [DATA_W-1:0] rs_val;
   logic [DATA_W-1:0] rt_val;
   ctl_t              ctl_dec;
   logic              op_bad;
   logic              uses_rt;
   logic              load_ins;
   ctl_t              ctl_q;

   assign op      = Ins[31:26];
   assign rs_idx  = Ins[25:21];
   assign rt_idx  = Ins[20:16];
   assign rd_idx  = Ins[15:11];
   assign imm_ext = {{(DATA_W-16){Ins[15]}}, Ins[15:0]};

   // Operand read: $0 is hardwired to zero; optional same-cycle writeback bypass.
   always_comb begin
      rs_val = (rs_idx == 5'd0) ? '0 : regs[rs_idx];
      rt_val = (rt_idx == 5'd0) ? '0 : regs[rt_idx];
`ifdef RF_WRITE_BYPASS_EN
      if (wb_we && (wb_addr != 5'd0) && (wb_addr == rs_idx)) rs_val = wb_data;
      if (wb_we && (wb_addr != 5'd0) && (wb_addr == rt_idx)) rt_val = wb_data;
`endif
   end

   // Opcode decode into control bits; anything unrecognised decodes to all-zero control.
   always_comb begin
      ctl_dec = '0;
      op_bad  = 1'b0;
      uses_rt = 1'b0;
      case (op)
         OP_RTYPE: begin
            ctl_dec.regdst   = 1'b1;
            ctl_dec.regwrite = 1'b1;
            uses_rt          = 1'b1;
         end
         OP_ADDI: begin
            ctl_dec.alusrc   = 1'b1;
            ctl_dec.regwrite = 1'b1;
         end
         OP_LW: begin
            ctl_dec.alusrc   = 1'b1;
            ctl_dec.memread  = 1'b1;
            ctl_dec.memtoreg = 1'b1;
            ctl_dec.regwrite = 1'b1;
         end
         OP_SW: begin
            ctl_dec.alusrc   = 1'b1;
            ctl_dec.memwrite = 1'b1;
            uses_rt          = 1'b1;
         end
         OP_BEQ: begin
            ctl_dec.branch   = 1'b1;
            uses_rt          = 1'b1;
         end
         default: op_bad = 1'b1;
      endcase
   end

   // Load-use hazard against the load sitting in ID/EX; flush takes precedence at the register but stall still shows.
   always_comb begin
      stall    = in_valid & out_valid & ctl_q.memread & (out_rt != 5'd0) &
                 ((out_rt == rs_idx) | (uses_rt & (out_rt == rt_idx)));
      load_ins = in_valid & ~flush & ~stall;
   end

   // Architectural register file with writeback port; $0 is never written.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
      end else if (wb_we && (wb_addr != 5'd0)) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // ID/EX pipeline register: decoded instruction or a zeroed bubble.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         out_valid   <= 1'b0;
         out_pc4     <= '0;
         out_rs_data <= '0;
         out_rt_data <= '0;
         out_imm     <= '0;
         out_rs      <= '0;
         out_rt      <= '0;
         out_rd      <= '0;
         out_funct   <= '0;
         ctl_q       <= '0;
      end else if (load_ins) begin
         out_valid   <= 1'b1;
         out_pc4     <= nextPC;
         out_rs_data <= rs_val;
         out_rt_data <= rt_val;
         out_imm     <= imm_ext;
         out_rs      <= rs_idx;
         out_rt      <= rt_idx;
         out_rd      <= rd_idx;
         out_funct   <= Ins[5:0];
         ctl_q       <= ctl_dec;
      end else begin
         out_valid   <= 1'b0;
         out_pc4     <= '0;
         out_rs_data <= '0;
         out_rt_data <= '0;
         out_imm     <= '0;
         out_rs      <= '0;
         out_rt      <= '0;
         out_rd      <= '0;
         out_funct   <= '0;
         ctl_q       <= '0;
      end
   end

   // Sticky unsupported-opcode flag, cleared only by reset.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)                   illegal <= 1'b0;
      else if (in_valid && op_bad) illegal <= 1'b1;
   end

   assign out_regwrite = ctl_q.regwrite;
   assign out_memread  = ctl_q.memread;
   assign out_memwrite = ctl_q.memwrite;
   assign out_branch   = ctl_q.branch;
   assign out_alusrc   = ctl_q.alusrc;
   assign out_regdst   = ctl_q.regdst;
   assign out_memtoreg = ctl_q.memtoreg;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, regfile, decode, load-use stall, flush, bypass behaviour, illegal flag.
// Latency: outputs sampled 1 time unit after each rising edge; stall sampled combinationally mid-cycle.
// Backpressure: stall is observed and the same instruction is re-presented while it is high.
module tb_id_stage;

   logic        CLK;
   logic        RST;
   logic [31:0] Ins;
   logic [31:0] nextPC;
   logic        in_valid;
   logic        flush;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        stall;
   logic        illegal;
   logic        out_valid;
   logic [31:0] out_pc4;
   logic [31:0] out_rs_data;
   logic [31:0] out_rt_data;
   logic [31:0] out_imm;
   logic [4:0]  out_rs;
   logic [4:0]  out_rt;
   logic [4:0]  out_rd;
   logic [5:0]  out_funct;
   logic        out_regwrite, out_memread, out_memwrite, out_branch;
   logic        out_alusrc, out_regdst, out_memtoreg;

   int n_assert = 0;
   int n_fail   = 0;

   // Control bits in order {regwrite,memread,memwrite,branch,alusrc,regdst,memtoreg}.
   logic [6:0] ctl;
   assign ctl = {out_regwrite, out_memread, out_memwrite, out_branch,
                 out_alusrc, out_regdst, out_memtoreg};

   id_stage dut (
      .CLK(CLK), .RST(RST), .Ins(Ins), .nextPC(nextPC), .in_valid(in_valid),
      .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .stall(stall), .illegal(illegal), .out_valid(out_valid), .out_pc4(out_pc4),
      .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm(out_imm),
      .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_funct(out_funct),
      .out_regwrite(out_regwrite), .out_memread(out_memread), .out_memwrite(out_memwrite),
      .out_branch(out_branch), .out_alusrc(out_alusrc), .out_regdst(out_regdst),
      .out_memtoreg(out_memtoreg)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   localparam logic [31:0] I_ADD_10_9_0  = 32'h01205020;
   localparam logic [31:0] I_ADD_1_0_0   = 32'h00000820;
   localparam logic [31:0] I_ADDI_8_9    = 32'h2128FF80;
   localparam logic [31:0] I_LW_17_18    = 32'h8E510004;
   localparam logic [31:0] I_ADD_9_17_10 = 32'h022A4820;
   localparam logic [31:0] I_ADD_1_5_0   = 32'h00A00820;
   localparam logic [31:0] I_ADD_1_9_0   = 32'h01200820;
   localparam logic [31:0] I_BAD         = 32'hFC000000;

   initial begin
      RST = 1'b1; Ins = '0; nextPC = '0; in_valid = 1'b0; flush = 1'b0;
      wb_we = 1'b0; wb_addr = '0; wb_data = '0;
      #1 RST = 1'b0;
      #2;
      chk("rst_valid",   {31'd0, out_valid}, 32'd0);
      chk("rst_illegal", {31'd0, illegal},   32'd0);
      chk("rst_ctl",     {25'd0, ctl},       32'd0);
      chk("rst_stall",   {31'd0, stall},     32'd0);
      #9 RST = 1'b1;

      // Writebacks: $9=0x1234, $0 attempt, $10=0x55
      wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h1234;
      tick();
      wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
      tick();
      wb_addr = 5'd10; wb_data = 32'h55;
      tick();
      wb_we = 1'b0;

      // add $10,$9,$0
      Ins = I_ADD_10_9_0; nextPC = 32'h100; in_valid = 1'b1;
      tick();
      chk("add_valid",  {31'd0, out_valid}, 32'd1);
      chk("add_rs",     out_rs_data, 32'h1234);
      chk("add_rt",     out_rt_data, 32'h0);
      chk("add_rd",     {27'd0, out_rd}, 32'd10);
      chk("add_ctl",    {25'd0, ctl}, 32'b1000010);
      chk("add_pc4",    out_pc4, 32'h100);
      chk("add_funct",  {26'd0, out_funct}, 32'h20);

      // read $0 after an attempted write of all ones
      Ins = I_ADD_1_0_0; nextPC = 32'h104;
      tick();
      chk("r0_read", out_rs_data, 32'h0);

      // addi $8,$9,-128
      Ins = I_ADDI_8_9; nextPC = 32'h108;
      tick();
      chk("addi_imm", out_imm, 32'hFFFFFF80);
      chk("addi_ctl", {25'd0, ctl}, 32'b1000100);
      chk("addi_rt",  {27'd0, out_rt}, 32'd8);

      // lw $17,4($18) then dependent add $9,$17,$10
      Ins = I_LW_17_18; nextPC = 32'h10C;
      #1 chk("lw_nostall", {31'd0, stall}, 32'd0);
      tick();
      chk("lw_ctl", {25'd0, ctl}, 32'b1100101);
      chk("lw_rt",  {27'd0, out_rt}, 32'd17);
      Ins = I_ADD_9_17_10; nextPC = 32'h110;
      #1 chk("lu_stall", {31'd0, stall}, 32'd1);
      tick();
      chk("lu_bubble_valid", {31'd0, out_valid}, 32'd0);
      chk("lu_bubble_ctl",   {25'd0, ctl}, 32'd0);
      #1 chk("lu_stall_drop", {31'd0, stall}, 32'd0);
      tick();
      chk("lu_add_valid", {31'd0, out_valid}, 32'd1);
      chk("lu_add_rs",    {27'd0, out_rs}, 32'd17);
      chk("lu_add_rtdat", out_rt_data, 32'h55);
      chk("lu_add_rd",    {27'd0, out_rd}, 32'd9);

      // flush with a valid instruction
      Ins = I_ADD_10_9_0; nextPC = 32'h114; flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_valid", {31'd0, out_valid}, 32'd0);
      chk("fl_ctl",   {25'd0, ctl}, 32'd0);
      chk("fl_data",  out_rs_data, 32'h0);

      // flush together with stall
      Ins = I_LW_17_18; nextPC = 32'h118;
      tick();
      Ins = I_ADD_9_17_10; nextPC = 32'h11C; flush = 1'b1;
      #1 chk("fs_stall", {31'd0, stall}, 32'd1);
      tick();
      flush = 1'b0;
      chk("fs_valid", {31'd0, out_valid}, 32'd0);
      chk("fs_ctl",   {25'd0, ctl}, 32'd0);
      #1 chk("fs_stall_drop", {31'd0, stall}, 32'd0);
      tick();
      chk("fs_next_valid", {31'd0, out_valid}, 32'd1);

      // same-cycle write and read of $5
      in_valid = 1'b0;
      wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h11;
      tick();
      Ins = I_ADD_1_5_0; nextPC = 32'h120; in_valid = 1'b1; wb_data = 32'hAA;
      tick();
      wb_we = 1'b0;
`ifdef RF_WRITE_BYPASS_EN
      chk("byp_same", out_rs_data, 32'hAA);
`else
      chk("byp_same", out_rs_data, 32'h11);
`endif
      tick();
      chk("byp_after", out_rs_data, 32'hAA);

      // unsupported opcode
      Ins = I_BAD; nextPC = 32'h124;
      tick();
      chk("ill_flag",  {31'd0, illegal}, 32'd1);
      chk("ill_ctl",   {25'd0, ctl}, 32'd0);
      Ins = I_ADD_10_9_0; nextPC = 32'h128;
      tick();
      chk("ill_sticky", {31'd0, illegal}, 32'd1);

      // asynchronous reset mid-cycle
      #2 RST = 1'b0;
      #1;
      chk("arst_valid",   {31'd0, out_valid}, 32'd0);
      chk("arst_illegal", {31'd0, illegal}, 32'd0);
      chk("arst_pc4",     out_pc4, 32'h0);
      chk("arst_rsdat",   out_rs_data, 32'h0);
      chk("arst_ctl",     {25'd0, ctl}, 32'd0);
      #1 RST = 1'b1;
      Ins = I_ADD_1_9_0; nextPC = 32'h200;
      tick();
      chk("arst_rf_clear", out_rs_data, 32'h0);
      chk("arst_resume",   {31'd0, out_valid}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Instruction-decode stage directly downstream of the fetch stage; consumes fetched Ins and nextPC each cycle.
- Holds the 32x32 architectural register file, with writeback from the WB stage.
- Decodes the MIPS subset (R-type add/sub/and/or/slt, addi, lw, sw, beq) and sign-extends the immediate.
- Registers everything into the ID/EX pipeline register.
- Detects load-use hazards and requests a one-cycle fetch stall.

Parameters:
REG_NUM, 32, number of architectural registers (index width fixed at 5)
DATA_W, 32, datapath width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-low reset
Ins  in  32  instruction from fetch stage
nextPC  in  32  PC+4 from fetch stage
in_valid  in  1  Ins/nextPC hold a real instruction
flush  in  1  branch taken in EX; kill the instruction currently in ID
wb_we  in  1  register-file write enable
wb_addr  in  5  write register index
wb_data  in  32  write data
stall  out  1  combinational; fetch must hold PC and Ins this cycle
illegal  out  1  sticky unsupported-opcode flag
out_valid  out  1  ID/EX holds a real instruction
out_pc4  out  32  registered nextPC
out_rs_data, out_rt_data  out  32 each  register operands
out_imm  out  32  sign-extended Ins[15:0]
out_rs, out_rt, out_rd  out  5 each  register indices
out_funct  out  6  Ins[5:0]
out_regwrite, out_memread, out_memwrite, out_branch, out_alusrc, out_regdst, out_memtoreg  out  1 each  control bits

Behaviour:
- Reset (RST=0, asynchronous): all registers and all registered outputs go to 0, illegal=0.
- Register file:
  - Written on the rising edge when wb_we=1 and wb_addr!=0.
  - Register 0 always reads 0.
  - Reads are combinational from Ins[25:21] and Ins[20:16].
- Decode, with op=Ins[31:26]:
  - op 000000: regdst, regwrite.
  - 001000 (addi): alusrc, regwrite.
  - 100011 (lw): alusrc, memread, memtoreg, regwrite.
  - 101011 (sw): alusrc, memwrite.
  - 000100 (beq): branch.
  - Any other op with in_valid=1: all control bits 0, and illegal is set; it stays set until reset.
- uses_rt = op is 000000, 101011 or 000100.
- Hazard:
  - stall = in_valid & out_valid & out_memread & (out_rt!=0) & (out_rt==Ins[25:21] | (uses_rt & out_rt==Ins[20:16])).
- Each rising edge, priority order:
  1. flush=1: load a bubble (out_valid=0, all control bits 0; data fields don't-care but driven to 0).
  2. stall=1: load a bubble. Fetch holds, so the same Ins is re-presented next cycle; the stall lasts exactly 1 cycle because the bubble clears out_memread.
  3. in_valid=0: load a bubble.
  4. Otherwise: out_valid=1 and load the decoded fields, operands, out_pc4=nextPC and control bits.
- Latency: 1 cycle from Ins/nextPC to the out_* fields.
- Simultaneous flush and stall: flush wins and stall is still asserted that cycle; the next cycle has out_valid=0, so stall deasserts.
- Register-file read and write to the same index in the same cycle without the optional feature: the read returns the old value.

Optional Feature:
Macro RF_WRITE_BYPASS_EN.
- Defined: if wb_we=1, wb_addr!=0 and wb_addr matches a read index, that operand takes wb_data in the same cycle (write-before-read). This removes the need for a 3-cycle writeback separation.
- Undefined: reads return the stored value only; hazards are resolved by software or EX forwarding.

Test Plan:
- Reset, then write wb_addr=9, wb_data=0x1234. Then present add $10,$9,$0 (0x01205020) -> next cycle out_rs_data=0x1234, out_rt_data=0, out_rd=10, out_regdst=1, out_regwrite=1, out_valid=1.
- wb_addr=0 with wb_data=0xFFFFFFFF, then read $0 -> out_rs_data=0.
- Present addi with imm=0xFF80 -> out_imm=0xFFFFFF80 and out_alusrc=1.
- lw $17,4($18), then add $9,$17,$10 -> stall=1 for exactly one cycle; a bubble is inserted; the add appears on the following edge with out_valid=1.
- Assert flush with a valid instruction, and again flush with stall together -> out_valid=0, all control bits 0.
- Same-cycle write of $5=0xAA and read of $5 -> with the macro out_rs_data=0xAA; without it the old value.
- op=111111 -> illegal=1 and stays 1; control bits 0. Pulse RST low mid-run -> all outputs 0 immediately, without waiting for a clock edge.
